// File: rtl/gpio_irq_filter.sv
// gpio_irq_filter: input-side engine for the GPIO peripheral.
// Each pin passes through a multi-flop synchroniser, then a prescaled
// debounce filter, then edge/level interrupt detection feeding sticky pending
// bits. The register file owns every cfg/clear input and reads back the
// filtered pin values and the pending bits.
// There is no valid/ready handshake here: irq_clr_i is a one-cycle
// write-1-to-clear strobe, and every other input is static configuration.
module gpio_irq_filter #(
   parameter int GPIO_W      = 32,
   parameter int SYNC_STAGES = 2,
   parameter int PSC_W       = 16,
   parameter int DB_W        = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [GPIO_W-1:0]     gpio_in_i,
   input  logic [PSC_W-1:0]      psc_div_i,
   input  logic [DB_W-1:0]       db_limit_i,
   input  logic [3*GPIO_W-1:0]   irq_mode_i,
   input  logic [GPIO_W-1:0]     irq_mask_i,
   input  logic [GPIO_W-1:0]     irq_clr_i,
   output logic [GPIO_W-1:0]     gpio_sync_o,
   output logic [GPIO_W-1:0]     gpio_filt_o,
   output logic [GPIO_W-1:0]     irq_pend_o,
   output logic                  irq_o
);

   // Per-pin interrupt mode encoding
   localparam logic [2:0] MODE_RISE = 3'd1;
   localparam logic [2:0] MODE_FALL = 3'd2;
   localparam logic [2:0] MODE_BOTH = 3'd3;
   localparam logic [2:0] MODE_HIGH = 3'd4;
   localparam logic [2:0] MODE_LOW  = 3'd5;

   logic [GPIO_W-1:0] sync_q [SYNC_STAGES];
   logic [GPIO_W-1:0] sync;
   logic [PSC_W-1:0]  psc_cnt_q;
   logic              tick;
   logic [GPIO_W-1:0] filt_q;
   logic [GPIO_W-1:0] prev_q;
   logic [DB_W-1:0]   db_cnt_q [GPIO_W];
   logic [GPIO_W-1:0] rise;
   logic [GPIO_W-1:0] fall;
   logic [GPIO_W-1:0] pend_set;
   logic [GPIO_W-1:0] pend_q;

   assign sync = sync_q[SYNC_STAGES-1];

   // Synchroniser chain: stage 0 samples the pads, the last stage is the output
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int s = 0; s < SYNC_STAGES; s++) begin
            sync_q[s] <= '0;
         end
      end else begin
         sync_q[0] <= gpio_in_i;
         for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_q[s] <= sync_q[s-1];
         end
      end
   end

   // Tick fires only on an exact match, so lowering psc_div_i below the
   // current count wraps the counter to 0 without producing a tick.
   assign tick = (psc_cnt_q == psc_div_i);

   // Shared free-running debounce prescaler
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         psc_cnt_q <= '0;
      end else if (psc_cnt_q >= psc_div_i) begin
         psc_cnt_q <= '0;
      end else begin
         psc_cnt_q <= psc_cnt_q + PSC_W'(1);
      end
   end

   // Per-pin debounce: accept a change after db_limit_i consecutive ticks of disagreement
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         filt_q <= '0;
         for (int p = 0; p < GPIO_W; p++) begin
            db_cnt_q[p] <= '0;
         end
      end else begin
         for (int p = 0; p < GPIO_W; p++) begin
            if (db_limit_i == '0) begin
               filt_q[p]   <= sync[p];
               db_cnt_q[p] <= '0;
            end else if (sync[p] == filt_q[p]) begin
               db_cnt_q[p] <= '0;
            end else if (tick) begin
               // limit is non-zero here, so limit-1 cannot underflow
               if (db_cnt_q[p] == (db_limit_i - DB_W'(1))) begin
                  filt_q[p]   <= sync[p];
                  db_cnt_q[p] <= '0;
               end else begin
                  db_cnt_q[p] <= db_cnt_q[p] + DB_W'(1);
               end
            end
         end
      end
   end

   // Previous filtered value for edge detection
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         prev_q <= '0;
      end else begin
         prev_q <= filt_q;
      end
   end

   assign rise = filt_q & ~prev_q;
   assign fall = ~filt_q & prev_q;

   // Decode each pin's mode into a pending-set request
   always_comb begin
      pend_set = '0;
      for (int p = 0; p < GPIO_W; p++) begin
         case (irq_mode_i[3*p +: 3])
            MODE_RISE: pend_set[p] = rise[p];
            MODE_FALL: pend_set[p] = fall[p];
            MODE_BOTH: pend_set[p] = rise[p] | fall[p];
            MODE_HIGH: pend_set[p] = filt_q[p];
            MODE_LOW:  pend_set[p] = ~filt_q[p];
            default:   pend_set[p] = 1'b0;
         endcase
      end
   end

   // Sticky pending bits; a set in the same cycle as a clear wins
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pend_q <= '0;
      end else begin
         pend_q <= pend_set | (pend_q & ~irq_clr_i);
      end
   end

   assign gpio_sync_o = sync;
   assign gpio_filt_o = filt_q;
   assign irq_pend_o  = pend_q;
   assign irq_o       = |(pend_q & irq_mask_i);

endmodule

// File: doc/gpio_irq_filter.md
Name: gpio_irq_filter

Overview:
- Parametrised input-side engine for the next-generation GPIO peripheral.
- Per pin, in order: multi-stage synchroniser, prescaled debounce filter, programmable interrupt detection (edge or level), then sticky pending bits with mask and clear.
- Sits between the pads and the APB4 register file; the register file drives all cfg/clear inputs and reads back filtered values and pending bits.

Parameters:
- GPIO_W, 32, number of pins.
- SYNC_STAGES, 2, synchroniser flops per pin (legal ≥2).
- PSC_W, 16, width of shared debounce prescaler.
- DB_W, 8, width of per-pin debounce counter and limit.

Ports:
- clk_i  in  1  core clock.
- rst_i  in  1  asynchronous, active-high reset.
- gpio_in_i  in  GPIO_W  raw pad inputs (asynchronous).
- psc_div_i  in  PSC_W  debounce tick period minus one.
- db_limit_i  in  DB_W  consecutive ticks required to accept a change; 0 = bypass.
- irq_mode_i  in  3*GPIO_W  per-pin mode; pin n uses bits [3n+2:3n].
- irq_mask_i  in  GPIO_W  1 = pin may drive irq_o.
- irq_clr_i  in  GPIO_W  one-cycle write-1-to-clear of pending bits.
- gpio_sync_o  out  GPIO_W  synchroniser output (last stage).
- gpio_filt_o  out  GPIO_W  debounced pin value.
- irq_pend_o  out  GPIO_W  sticky pending bits (unmasked).
- irq_o  out  1  OR of (irq_pend_o & irq_mask_i).

Behaviour:
- Reset (async assert, sync release):
  - All synchroniser flops, filtered values, previous-filtered values, debounce counters, prescaler and pending bits go to 0.
  - Outputs therefore read 0 and irq_o = 0.
  - Reset mid-operation discards in-progress debounce counts and pending bits immediately.
- Synchroniser: gpio_sync_o lags gpio_in_i by SYNC_STAGES clk_i edges.
- Prescaler:
  - Free-running counter 0..psc_div_i.
  - tick = 1 for one cycle when the counter equals psc_div_i, then it wraps to 0.
  - psc_div_i = 0 gives tick every cycle.
  - If psc_div_i is lowered below the current count, the counter wraps to 0 on the next cycle with no tick.
- Debounce, per pin:
  - db_limit_i = 0: filt loads sync every cycle (1-cycle latency); counter held at 0.
  - Otherwise, if sync == filt in a cycle: cnt <= 0.
  - Otherwise, on a tick: if cnt+1 == db_limit_i then filt <= sync and cnt <= 0, else cnt <= cnt+1.
  - Otherwise, with no tick: cnt holds.
  - A glitch shorter than db_limit_i consecutive ticks never reaches filt.
- Edge detection: prev <= filt every cycle; rise = filt & ~prev; fall = ~filt & prev.
- Modes (per pin):
  - 0 = disabled.
  - 1 = rising.
  - 2 = falling.
  - 3 = both edges.
  - 4 = level high (filt == 1).
  - 5 = level low (filt == 0).
  - 6, 7 = disabled.
- Pending, per pin: pend <= set | (pend & ~clr).
  - A set event and a clear in the same cycle leave pend = 1 (set wins).
  - Level modes re-assert pend every cycle the level holds, so a clear is effective only once the level is gone.
  - Changing mode does not clear pend.
  - Mode 0/6/7 never sets pend, but existing pend stays until cleared.
- irq_o is combinational from pend and irq_mask_i; the mask affects only irq_o, never pend.
- Latency (bypass debounce): pad edge → gpio_sync_o after SYNC_STAGES cycles → gpio_filt_o +1 → irq_pend_o/irq_o +1.
- After reset, a pad held high produces a rising event once filt first rises. Firmware clears pend after configuring.

Test Plan:
- Reset and bypass:
  - Stimulus: rst_i high with gpio_in_i = 32'hFFFF_FFFF; all outputs 0. Release, db_limit=0, mode pin0 = 1, mask pin0 = 1.
  - Required: gpio_sync_o[0] = 1 after 2 cycles, gpio_filt_o[0] = 1 after 3, irq_pend_o[0] and irq_o = 1 after 4.
- Edge modes:
  - Stimulus: pin3 mode 2, pin4 mode 3; toggle both 0→1→0 (8 cycles each phase).
  - Required: pin3 pend set only on the fall. Pin4 sets on the rise; after clr it sets again on the fall.
- Level and set-wins:
  - Stimulus: pin5 mode 4 held high; pulse irq_clr_i[5].
  - Required: pend[5] stays 1. Drop pin low, then clr: pend[5] = 0 next cycle.
  - Also: an edge event coincident with clr leaves pend = 1.
- Debounce:
  - Stimulus: psc_div=3, db_limit=4; 10-cycle high glitch on pin7.
  - Required: gpio_filt_o[7] stays 0.
  - Stimulus: hold pin7 high for 20 cycles.
  - Required: filt rises after the 4th tick after sync goes high, i.e. 13–16 cycles after the sync change, with SYNC_STAGES added from the pad.
- Mask:
  - Stimulus: pend[9] = 1 with mask[9] = 0.
  - Required: irq_o = 0 and irq_pend_o[9] = 1. Set mask → irq_o = 1 in the same cycle.
- Reset mid-debounce:
  - Stimulus: assert rst_i while cnt ≠ 0 and pend ≠ 0.
  - Required: all pend and filt = 0 asynchronously. After release, the count restarts from 0 (full db_limit required).
